// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, coin and
// change-coin values (in units of 10 cents) and stock counter constants.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COIN   = 2'd1,
    ST_VEND   = 2'd2,
    ST_REFUND = 2'd3
  } vend_state_e;

  typedef enum logic [1:0] {
    CHG_10  = 2'd0,
    CHG_20  = 2'd1,
    CHG_50  = 2'd2,
    CHG_100 = 2'd3
  } change_code_e;

  localparam int COIN_VAL_10  = 1;
  localparam int COIN_VAL_20  = 2;
  localparam int COIN_VAL_50  = 5;
  localparam int COIN_VAL_100 = 10;

  localparam int              STOCK_W    = 4;
  localparam logic [STOCK_W-1:0] STOCK_INIT = 4'd9;

  function automatic int unsigned change_value(change_code_e code);
    int unsigned v;
    case (code)
      CHG_10:  v = COIN_VAL_10;
      CHG_20:  v = COIN_VAL_20;
      CHG_50:  v = COIN_VAL_50;
      default: v = COIN_VAL_100;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Greedy change selection: offers the largest coin not exceeding the credit and
// reports how much credit a completed valid/ready handshake consumes.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int MONEY_W = 10
) (
  input  logic [MONEY_W-1:0] credit_i,
  input  logic               en_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [1:0]         code_o,
  output logic [MONEY_W-1:0] dec_o
);

  change_code_e code;

  always_comb begin
    if (credit_i >= MONEY_W'(COIN_VAL_100))     code = CHG_100;
    else if (credit_i >= MONEY_W'(COIN_VAL_50)) code = CHG_50;
    else if (credit_i >= MONEY_W'(COIN_VAL_20)) code = CHG_20;
    else                                        code = CHG_10;
  end

  // The offered coin is a pure function of credit, which only moves on a
  // handshake, so valid/code stay stable while the hopper is not ready.
  assign valid_o = en_i && (credit_i != '0);
  assign code_o  = code;
  assign dec_o   = (valid_o && ready_i) ? MONEY_W'(change_value(code)) : '0;

endmodule

// File: rtl/vend_controller.sv
// Vending machine controller: item select, coin credit, timed vend and greedy
// change refund. Define VEND_STOCK_EN to add per-item stock tracking.
//
// state  | meaning
// IDLE   | waiting for a product switch
// COIN   | collecting coins toward the latched price, idle timeout running
// VEND   | dispense motor on for VEND_S ticks
// REFUND | paying out remaining credit, minimum REFUND_S ticks
module vend_controller
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 3,
  parameter int MONEY_W   = 10,
  parameter int TIMEOUT_S = 10,
  parameter int VEND_S    = 2,
  parameter int REFUND_S  = 2,
  localparam int IDX_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick_1hz,
  input  logic [NUM_ITEMS-1:0]         sel_i,
  input  logic [NUM_ITEMS*MONEY_W-1:0] prices_i,
  input  logic [2:0]                   coin_i,
  input  logic                         cancel_i,
  input  logic                         change_ready_i,
  output logic [1:0]                   state_o,
  output logic [MONEY_W-1:0]           credit_o,
  output logic [IDX_W-1:0]             item_o,
  output logic                         vend_o,
  output logic                         change_valid_o,
  output logic [1:0]                   change_coin_o
`ifdef VEND_STOCK_EN
  ,
  input  logic                         restock_i,
  output logic [NUM_ITEMS-1:0]         soldout_o
`endif
);

  localparam int T_MAX = (TIMEOUT_S > VEND_S) ?
                         ((TIMEOUT_S > REFUND_S) ? TIMEOUT_S : REFUND_S) :
                         ((VEND_S > REFUND_S) ? VEND_S : REFUND_S);
  localparam int TMR_W = $clog2(T_MAX + 1);

  vend_state_e          state_q, state_d;
  logic [MONEY_W-1:0]   credit_q, credit_d;
  logic [MONEY_W-1:0]   price_q, price_d;
  logic [IDX_W-1:0]     item_q, item_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 vend_q, vend_d;

  logic [NUM_ITEMS-1:0] avail;
  logic                 sel_hit;
  logic [IDX_W-1:0]     sel_idx;
  logic [MONEY_W-1:0]   sel_price;
  logic                 coin_hit;
  logic [MONEY_W-1:0]   coin_val;
  logic [MONEY_W:0]     coin_sum;
  logic [MONEY_W-1:0]   coin_credit;
  logic [MONEY_W-1:0]   chg_dec;

  vend_change_dispenser #(.MONEY_W(MONEY_W)) u_change (
    .credit_i (credit_q),
    .en_i     (state_q == ST_REFUND),
    .ready_i  (change_ready_i),
    .valid_o  (change_valid_o),
    .code_o   (change_coin_o),
    .dec_o    (chg_dec)
  );

  always_comb begin
    sel_hit   = 1'b0;
    sel_idx   = '0;
    sel_price = '0;
    // Descending scan so the lowest available selected index wins.
    for (int k = NUM_ITEMS - 1; k >= 0; k--) begin
      if (sel_i[k] && avail[k]) begin
        sel_hit   = 1'b1;
        sel_idx   = IDX_W'(k);
        sel_price = prices_i[k*MONEY_W +: MONEY_W];
      end
    end
  end

  always_comb begin
    coin_hit = |coin_i;
    if (coin_i[0])      coin_val = MONEY_W'(COIN_VAL_20);
    else if (coin_i[1]) coin_val = MONEY_W'(COIN_VAL_50);
    else if (coin_i[2]) coin_val = MONEY_W'(COIN_VAL_100);
    else                coin_val = '0;
    coin_sum    = {1'b0, credit_q} + {1'b0, coin_val};
    coin_credit = coin_sum[MONEY_W] ? '1 : coin_sum[MONEY_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    item_d   = item_q;
    timer_d  = timer_q;
    vend_d   = vend_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_hit) begin
          item_d   = sel_idx;
          price_d  = sel_price;
          credit_d = '0;
          timer_d  = '0;
          state_d  = ST_COIN;
        end
      end
      ST_COIN: begin
        if (credit_q >= price_q) begin
          state_d = ST_VEND;
          vend_d  = 1'b1;
          timer_d = '0;
        end else if (cancel_i) begin
          state_d = ST_REFUND;
          timer_d = '0;
        end else if (coin_hit) begin
          credit_d = coin_credit;
          timer_d  = '0;
        end else if (tick_1hz) begin
          if (timer_q == TMR_W'(TIMEOUT_S - 1)) begin
            state_d = ST_REFUND;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_VEND: begin
        if (tick_1hz) begin
          if (timer_q == TMR_W'(VEND_S - 1)) begin
            vend_d   = 1'b0;
            credit_d = credit_q - price_q;
            timer_d  = '0;
            state_d  = ST_REFUND;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_REFUND: begin
        credit_d = credit_q - chg_dec;
        if (tick_1hz && (timer_q < TMR_W'(REFUND_S))) timer_d = timer_q + 1'b1;
        if ((credit_q == '0) && (timer_q >= TMR_W'(REFUND_S)) && (sel_i == '0)) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      price_q  <= '0;
      item_q   <= '0;
      timer_q  <= '0;
      vend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      item_q   <= item_d;
      timer_q  <= timer_d;
      vend_q   <= vend_d;
    end
  end

  assign state_o  = state_q;
  assign credit_o = credit_q;
  assign item_o   = item_q;
  assign vend_o   = vend_q;

`ifdef VEND_STOCK_EN
  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_q, stock_d;
  logic                              vend_exit;

  assign vend_exit = (state_q == ST_VEND) && tick_1hz && (timer_q == TMR_W'(VEND_S - 1));

  always_comb begin
    stock_d = stock_q;
    avail   = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      avail[k] = (stock_q[k] != '0);
      if (restock_i) stock_d[k] = STOCK_INIT;
      else if (vend_exit && (item_q == IDX_W'(k))) stock_d[k] = stock_q[k] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stock_q <= {NUM_ITEMS{STOCK_INIT}};
    else        stock_q <= stock_d;
  end

  assign soldout_o = ~avail;
`else
  assign avail = '1;
`endif

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller; change coins are scoreboarded
// against a queue filled when each scenario's payout becomes known.
module tb_vend_controller;

  localparam int NI = 3;
  localparam int MW = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            tick_1hz = 1'b0;
  logic [NI-1:0]   sel_i = '0;
  logic [NI*MW-1:0] prices_i;
  logic [2:0]      coin_i = '0;
  logic            cancel_i = 1'b0;
  logic            change_ready_i = 1'b1;
  logic [1:0]      state_o;
  logic [MW-1:0]   credit_o;
  logic [1:0]      item_o;
  logic            vend_o;
  logic            change_valid_o;
  logic [1:0]      change_coin_o;
`ifdef VEND_STOCK_EN
  logic            restock_i = 1'b0;
  logic [NI-1:0]   soldout_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  vend_controller #(
    .NUM_ITEMS(NI), .MONEY_W(MW), .TIMEOUT_S(10), .VEND_S(2), .REFUND_S(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick_1hz       (tick_1hz),
    .sel_i          (sel_i),
    .prices_i       (prices_i),
    .coin_i         (coin_i),
    .cancel_i       (cancel_i),
    .change_ready_i (change_ready_i),
    .state_o        (state_o),
    .credit_o       (credit_o),
    .item_o         (item_o),
    .vend_o         (vend_o),
    .change_valid_o (change_valid_o),
    .change_coin_o  (change_coin_o)
`ifdef VEND_STOCK_EN
    ,
    .restock_i      (restock_i),
    .soldout_o      (soldout_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs settle at posedge+1, so a handshake is decided by negedge.
  always @(negedge clk) begin
    if (rst_n && change_valid_o && change_ready_i) begin
      if (exp_q.size() == 0) check_eq("chg_unexpected", 32'(change_valid_o), 32'd0);
      else                   check_eq("chg_code", 32'(change_coin_o), 32'(exp_q.pop_front()));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic coin(input logic [2:0] bits);
    coin_i = bits;
    step();
    coin_i = '0;
  endtask

  task automatic select(input logic [NI-1:0] bits);
    sel_i = bits;
    step();
    sel_i = '0;
  endtask

  task automatic cancel();
    cancel_i = 1'b1;
    step();
    cancel_i = 1'b0;
  endtask

  task automatic finish_refund(input string tag);
    tick();
    tick();
    step();
    check_eq(tag, 32'(state_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prices_i = {10'd1023, 10'd7, 10'd3};
    #12;
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_credit", 32'(credit_o), 32'd0);
    check_eq("rst_vend", 32'(vend_o), 32'd0);
    check_eq("rst_chg_valid", 32'(change_valid_o), 32'd0);
    check_eq("rst_item", 32'(item_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check_eq("post_rst_idle", 32'(state_o), 32'd0);

    // Item 0 at 30c, two 20c coins: vend, 10c change, then IDLE.
    select(3'b001);
    check_eq("a_coin_state", 32'(state_o), 32'd1);
    check_eq("a_item", 32'(item_o), 32'd0);
    coin(3'b001);
    check_eq("a_credit1", 32'(credit_o), 32'd2);
    coin(3'b001);
    check_eq("a_credit2", 32'(credit_o), 32'd4);
    check_eq("a_still_coin", 32'(state_o), 32'd1);
    step();
    check_eq("a_vend_state", 32'(state_o), 32'd2);
    check_eq("a_vend_on", 32'(vend_o), 32'd1);
    exp_q.push_back(2'd0);
    tick();
    check_eq("a_vend_tick1", 32'(vend_o), 32'd1);
    tick();
    check_eq("a_vend_off", 32'(vend_o), 32'd0);
    check_eq("a_refund_state", 32'(state_o), 32'd3);
    check_eq("a_credit_left", 32'(credit_o), 32'd1);
    step();
    check_eq("a_credit_paid", 32'(credit_o), 32'd0);
    check_eq("a_valid_zero", 32'(change_valid_o), 32'd0);
    tick();
    check_eq("a_refund_min", 32'(state_o), 32'd3);
    tick();
    step();
    check_eq("a_idle", 32'(state_o), 32'd0);

    // Item 1, 50c then cancel; hopper stalls for three cycles.
    select(3'b010);
    check_eq("b_item", 32'(item_o), 32'd1);
    change_ready_i = 1'b0;
    coin(3'b010);
    check_eq("b_credit", 32'(credit_o), 32'd5);
    cancel();
    check_eq("b_refund", 32'(state_o), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("b_hold_valid", 32'(change_valid_o), 32'd1);
      check_eq("b_hold_code", 32'(change_coin_o), 32'd2);
      check_eq("b_hold_credit", 32'(credit_o), 32'd5);
    end
    exp_q.push_back(2'd2);
    change_ready_i = 1'b1;
    step();
    check_eq("b_credit_paid", 32'(credit_o), 32'd0);
    finish_refund("b_idle");

    // Idle timeout with no coins, then a coin on tick 9 restarting the timer.
    select(3'b001);
    for (int i = 0; i < 9; i++) tick();
    check_eq("c1_tick9_coin", 32'(state_o), 32'd1);
    tick();
    check_eq("c1_tick10_refund", 32'(state_o), 32'd3);
    check_eq("c1_no_change", 32'(change_valid_o), 32'd0);
    finish_refund("c1_idle");
    select(3'b001);
    for (int i = 0; i < 8; i++) tick();
    coin_i = 3'b001;
    tick();
    coin_i = '0;
    check_eq("c2_coin_credit", 32'(credit_o), 32'd2);
    for (int i = 0; i < 9; i++) tick();
    check_eq("c2_restart_coin", 32'(state_o), 32'd1);
    exp_q.push_back(2'd1);
    tick();
    check_eq("c2_refund", 32'(state_o), 32'd3);
    finish_refund("c2_idle");

    // Coins and cancel in IDLE are ignored.
    coin_i = 3'b100;
    cancel_i = 1'b1;
    step();
    coin_i = '0;
    cancel_i = 1'b0;
    check_eq("idle_coin_state", 32'(state_o), 32'd0);
    check_eq("idle_coin_credit", 32'(credit_o), 32'd0);

    // Lowest selected index wins; cancel beats simultaneous coins.
    select(3'b110);
    check_eq("d_item_lowest", 32'(item_o), 32'd1);
    coin_i = 3'b011;
    cancel_i = 1'b1;
    step();
    coin_i = '0;
    cancel_i = 1'b0;
    check_eq("d_refund", 32'(state_o), 32'd3);
    check_eq("d_credit", 32'(credit_o), 32'd0);
    check_eq("d_no_change", 32'(change_valid_o), 32'd0);
    finish_refund("d_idle");

    // Credit saturation at 1023 and credit check beating cancel.
    select(3'b100);
    for (int i = 0; i < 102; i++) coin(3'b100);
    check_eq("s_credit_1020", 32'(credit_o), 32'd1020);
    coin(3'b100);
    check_eq("s_credit_sat", 32'(credit_o), 32'd1023);
    check_eq("s_still_coin", 32'(state_o), 32'd1);
    cancel();
    check_eq("s_vend_over_cancel", 32'(state_o), 32'd2);
    tick();
    tick();
    check_eq("s_credit_zero", 32'(credit_o), 32'd0);
    finish_refund("s_idle");

    // Asynchronous reset in the middle of a vend.
    select(3'b001);
    coin(3'b100);
    step();
    check_eq("e_vend_on", 32'(vend_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("e_rst_vend", 32'(vend_o), 32'd0);
    check_eq("e_rst_state", 32'(state_o), 32'd0);
    check_eq("e_rst_credit", 32'(credit_o), 32'd0);
    step(2);
    rst_n = 1'b1;
    step();
    check_eq("e_idle", 32'(state_o), 32'd0);

`ifdef VEND_STOCK_EN
    check_eq("f_full_stock", 32'(soldout_o), 32'd0);
    for (int n = 0; n < 9; n++) begin
      select(3'b001);
      coin(3'b100);
      step();
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd1);
      tick();
      tick();
      finish_refund("f_vend_idle");
    end
    check_eq("f_soldout0", 32'(soldout_o), 32'd1);
    select(3'b001);
    check_eq("f_soldout_stay", 32'(state_o), 32'd0);
    select(3'b011);
    check_eq("f_skip_item", 32'(item_o), 32'd1);
    check_eq("f_skip_state", 32'(state_o), 32'd1);
    cancel();
    finish_refund("f_skip_idle");
    restock_i = 1'b1;
    step();
    restock_i = 1'b0;
    check_eq("f_restocked", 32'(soldout_o), 32'd0);
    select(3'b001);
    check_eq("f_restock_sel", 32'(state_o), 32'd1);
    cancel();
    finish_refund("f_restock_idle");
`endif

    check_eq("chg_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 The block SHALL have parameter NUM_ITEMS, default 3: number of selectable products.
REQ-002 The block SHALL have parameter MONEY_W, default 10: credit/price width, unit = 10 cents.
REQ-003 The block SHALL have parameter TIMEOUT_S, default 10: idle seconds in COIN before auto-refund.
REQ-004 The block SHALL have parameter VEND_S, default 2: seconds vend_o stays high.
REQ-005 The block SHALL have parameter REFUND_S, default 2: minimum seconds spent in REFUND.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- tick_1hz  in  1  one-cycle strobe, once per second
- sel_i  in  NUM_ITEMS  product switches, level
- prices_i  in  NUM_ITEMS*MONEY_W  price table, item k at [k*MONEY_W +: MONEY_W]
- coin_i  in  3  one-cycle pulses: [0]=20, [1]=50, [2]=100
- cancel_i  in  1  one-cycle pulse
- change_ready_i  in  1  change-hopper ready
- state_o  out  2  IDLE=0, COIN=1, VEND=2, REFUND=3
- credit_o  out  MONEY_W  current credit
- item_o  out  clog2(NUM_ITEMS)  latched item index
- vend_o  out  1  dispense motor
- change_valid_o  out  1  change coin offered
- change_coin_o  out  2  0=10, 1=20, 2=50, 3=100

Function
REQ-007 In IDLE, when sel_i is nonzero, the block SHALL latch the lowest set index into item_o and its price, clear credit, clear the timer, and enter COIN on the next cycle.
REQ-008 In COIN, cancel_i SHALL take priority over coins; of simultaneous coins, only the lowest index SHALL be accepted.
REQ-009 Coin addition SHALL saturate at 2^MONEY_W-1.
REQ-010 credit_o >= price SHALL move COIN to VEND one cycle after the update, with the check taking priority over cancel_i in that cycle.
REQ-011 In COIN, the timer SHALL clear on each accepted coin and increment on each tick_1hz; when it reaches TIMEOUT_S, the block SHALL enter REFUND.
REQ-012 In VEND, vend_o SHALL be 1 for exactly VEND_S ticks; on exit, credit SHALL become credit-price, and the block SHALL enter REFUND.
REQ-013 In REFUND, change SHALL be dispensed greedily, offering the largest coin <= credit.
REQ-014 change_valid_o and change_coin_o SHALL be held stable until change_ready_i is sampled high.
REQ-015 On each change handshake, credit SHALL decrement by the coin value in the same edge.
REQ-016 change_valid_o SHALL be 0 when credit == 0.
REQ-017 REFUND SHALL exit to IDLE only when credit == 0, at least REFUND_S ticks have elapsed, and sel_i == 0.
REQ-018 Coins and cancel_i arriving outside COIN SHALL be ignored.

Reset
REQ-019 While rst_n is low, the block SHALL set state to IDLE and drive all outputs, credit, timer and latched price to 0, regardless of state, including mid-handshake.
REQ-020 The first rising clk after rst_n deasserts SHALL evaluate IDLE.

Configuration
REQ-021 With VEND_STOCK_EN defined, the block SHALL add input restock_i (1-bit pulse) and output soldout_o (NUM_ITEMS bits).
REQ-022 With VEND_STOCK_EN, each item SHALL have a 4-bit stock counter; reset and restock_i SHALL set it to 9.
REQ-023 With VEND_STOCK_EN, VEND exit SHALL decrement the counter of the vended item.
REQ-024 With VEND_STOCK_EN, selection SHALL skip items at stock 0, and IDLE SHALL remain if every selected item is sold out.
REQ-025 With VEND_STOCK_EN, soldout_o[k] SHALL equal (stock[k] == 0).
REQ-026 Without VEND_STOCK_EN, restock_i and soldout_o SHALL be absent, and every item SHALL always be available.

Structure
REQ-027 Package vend_pkg SHALL hold the state enum, coin values (10/20/50/100), change_coin codes and stock width/init constants.
REQ-028 The greedy dispense logic SHALL be sub-module vend_change_dispenser: inputs credit, valid/ready; outputs coin code and decrement value.

Verification
REQ-029 sel_i=001, price0=30, coin 20 then coin 20 -> VEND for 2 ticks, credit 10, then one change coin code 0, then IDLE after sel_i=0.
REQ-030 sel_i=010, price1=70, coin 50, cancel_i -> REFUND, change code 2 held across 3 cycles of change_ready_i=0, credit 0 after the handshake.
REQ-031 COIN with no coins for 10 ticks -> REFUND on the 10th tick; a coin at tick 9 -> timer restarts.
REQ-032 coin_i=011 together with cancel_i -> REFUND with credit 0, no coin accepted.
REQ-033 rst_n asserted mid-VEND -> vend_o=0, state_o=0, credit_o=0 immediately.
REQ-034 VEND_STOCK_EN: vend item0 nine times -> soldout_o[0]=1, next sel_i=001 stays IDLE; restock_i -> soldout_o[0]=0.
